// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Shifts one bit per period into a WIDTH-bit LED pattern. The bit comes either
// from an external active-low input or from a 7-bit LFSR (x^7 + x^6 + 1).
// A stop request drains the pattern by shifting in WIDTH zeros before the
// block returns to IDLE.
//
// Parameters
//   WIDTH : LED pattern width (>= 2)
//   DIV   : base shift period in clk cycles (8 .. 2^32-1)
//   SEED  : LFSR reset value, nonzero
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   single-cycle request to begin shifting
//   stop       in   single-cycle request to end shifting (wins over start)
//   src_sel    in   shift-bit source: 0 = ~data_n, 1 = LFSR
//   data_n     in   external data, active low
//   period_sel in   shift period = DIV >> period_sel
//   led_n      out  active-low LED drive, ~pattern (registered)
//   strobe     out  one-cycle pulse on the cycle the pattern shifts
//   busy       out  high whenever state is not IDLE
//   state      out  IDLE=0, RUN=1, DRAIN=2
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int unsigned WIDTH = 6,
    parameter logic [31:0] DIV   = 32'd27000000,
    parameter logic [6:0]  SEED  = 7'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             src_sel,
    input  logic             data_n,
    input  logic [1:0]       period_sel,
    output logic [WIDTH-1:0] led_n,
    output logic             strobe,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned    DCW      = $clog2(WIDTH + 1);
    localparam logic [DCW-1:0] DRN_ONE  = DCW'(1);
    localparam logic [DCW-1:0] DRN_LAST = DCW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      per_q, per_d;
    logic             src_q, src_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [DCW-1:0]   drn_q, drn_d;
    logic [WIDTH-1:0] led_n_q, led_n_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;

    logic [31:0]      per_sel;
    logic             tick;
    logic             shift_bit;

    assign per_sel = DIV >> period_sel;

    // The shift cycle: last count of the current period while active.
    assign tick = (state_q != ST_IDLE) && (cnt_q == per_q - 32'd1);

    // The bit chosen by the source latched at the previous period boundary.
    assign shift_bit = src_q ? lfsr_q[0] : ~data_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        src_d   = src_q;
        lfsr_d  = lfsr_q;
        pat_d   = pat_q;
        drn_d   = drn_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 32'd0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    per_d   = per_sel;
                    src_d   = src_sel;
                end
            end

            ST_RUN: begin
                cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
                if (tick) begin
                    pat_d = {pat_q[WIDTH-2:0], shift_bit};
                    per_d = per_sel;
                    src_d = src_sel;
                    if (src_q) begin
                        lfsr_d = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[6:1]};
                    end
                end
                // A strobe coinciding with stop still shifts the selected
                // bit; draining starts counting from the next strobe.
                if (stop) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                end
            end

            ST_DRAIN: begin
                cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
                if (tick) begin
                    pat_d = {pat_q[WIDTH-2:0], 1'b0};
                    per_d = per_sel;
                    src_d = src_sel;
                    if (drn_q == DRN_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 32'd0;
                        drn_d   = '0;
                    end else begin
                        drn_d = drn_q + DRN_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // Outputs are computed from next-state so the registered strobe is
        // high exactly while the counter sits on its last count.
        busy_d   = (state_d != ST_IDLE);
        strobe_d = busy_d && (cnt_d == per_d - 32'd1);
        led_n_d  = ~pat_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            per_q    <= DIV;
            src_q    <= 1'b0;
            lfsr_q   <= SEED;
            pat_q    <= '0;
            drn_q    <= '0;
            led_n_q  <= '1;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            src_q    <= src_d;
            lfsr_q   <= lfsr_d;
            pat_q    <= pat_d;
            drn_q    <= drn_d;
            led_n_q  <= led_n_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign led_n  = led_n_q;
    assign strobe = strobe_q;
    assign busy   = busy_q;
    assign state  = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int          W    = 6;
    localparam logic [31:0] DIVP = 32'd8;
    localparam logic [6:0]  SD   = 7'h01;

    logic         clk = 1'b0;
    logic         reset, start, stop, src_sel, data_n;
    logic [1:0]   period_sel;
    logic [W-1:0] led_n;
    logic         strobe, busy;
    logic [1:0]   state;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.WIDTH(W), .DIV(DIVP), .SEED(SD)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .src_sel(src_sel), .data_n(data_n), .period_sel(period_sel),
        .led_n(led_n), .strobe(strobe), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, sp, ss, dn;
        logic [1:0] ps;
        logic [5:0] led;
        logic       stb, bsy;
        logic [1:0] sta;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, st, sp, ss, dn, input logic [1:0] ps,
                                input logic [5:0] led, input logic stb, bsy,
                                input logic [1:0] sta);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.ss = ss; v.dn = dn; v.ps = ps;
        v.led = led; v.stb = stb; v.bsy = bsy; v.sta = sta;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, st, sp, ss, dn, input logic [1:0] ps);
        reset = rst; start = st; stop = sp; src_sel = ss; data_n = dn; period_sel = ps;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until strobe is observed; n = edges taken.
    task automatic wait_strobe(input int max, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < max && !ok) begin
            tick();
            n++;
            if (strobe === 1'b1) ok = 1'b1;
        end
    endtask

    // Polynomial x^7 + x^6 + 1, output taken from bit 0.
    function automatic int lfsr_next(input int l);
        return (l >> 1) | (((l ^ (l >> 1)) & 1) << 6);
    endfunction

    // Reference model: shift happens when 'rem' cycles remaining reaches 1.
    int m_mode, m_rem, m_src, m_lfsr, m_pat, m_drained;

    task automatic model_step(input logic rst, st, sp, ss, dn, input logic [1:0] ps);
        bit fire;
        int b;
        if (rst) begin
            m_mode = 0; m_rem = 0; m_src = 0; m_lfsr = int'(SD); m_pat = 0; m_drained = 0;
            return;
        end
        fire = (m_mode != 0) && (m_rem == 1);
        case (m_mode)
            0: if (st && !sp) begin
                   m_mode = 1; m_rem = int'(DIVP) >> ps; m_src = ss;
               end
            1: begin
                   if (fire) begin
                       b = m_src ? (m_lfsr % 2) : (dn ? 0 : 1);
                       m_pat = (m_pat * 2 + b) % (1 << W);
                       if (m_src) m_lfsr = lfsr_next(m_lfsr);
                       m_rem = int'(DIVP) >> ps;
                       m_src = ss;
                   end else m_rem--;
                   if (sp) begin m_mode = 2; m_drained = 0; end
               end
            default: begin
                   if (fire) begin
                       m_pat = (m_pat * 2) % (1 << W);
                       m_drained++;
                       m_rem = int'(DIVP) >> ps;
                       m_src = ss;
                       if (m_drained == W) m_mode = 0;
                   end else m_rem--;
               end
        endcase
    endtask

    initial begin
        int  n;
        bit  ok;
        int  l;
        int  pexp;

        apply(1'b1, 0, 0, 0, 0, 2'd0);

        // ---------------- table-driven vectors ----------------
        add(1, 0, 0, 0, 0, 0, 6'h3F, 0, 0, 0);                 // reset state
        add(0, 1, 1, 0, 0, 0, 6'h3F, 0, 0, 0);                 // start+stop in IDLE
        add(0, 1, 0, 0, 0, 0, 6'h3F, 0, 1, 1);                 // enter RUN
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 6'h3F, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'h3F, 1, 1, 1);                 // strobe cycle
        add(0, 0, 0, 0, 0, 0, 6'h3E, 0, 1, 1);                 // shifted a 1
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 6'h3E, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'h3E, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'h3C, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 6'h3C, 0, 1, 2);                 // start+stop in RUN
        add(0, 0, 0, 0, 0, 0, 6'h3C, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 6'h3F, 0, 0, 0);                 // reset mid-DRAIN

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ss, vecs[i].dn, vecs[i].ps);
            tick();
            check($sformatf("vec%0d", i), {22'd0, led_n, strobe, busy, state},
                  {22'd0, vecs[i].led, vecs[i].stb, vecs[i].bsy, vecs[i].sta});
        end

        // ---------------- period change mid-period ----------------
        apply(1, 0, 0, 0, 0, 2'd0); tick();
        apply(0, 1, 0, 0, 0, 2'd0); tick();
        apply(0, 0, 0, 0, 0, 2'd0);
        tick(); tick(); tick();
        period_sel = 2'd2;
        wait_strobe(20, n, ok);
        check("period_first_gap", n, ok ? 4 : -1);
        wait_strobe(20, n, ok);
        check("period_gap2", n, ok ? 2 : -1);
        wait_strobe(20, n, ok);
        check("period_gap3", n, ok ? 2 : -1);

        // ---------------- LFSR source ----------------
        apply(1, 0, 0, 1, 1, 2'd0); tick();
        apply(0, 1, 0, 1, 1, 2'd0); tick();
        apply(0, 0, 0, 1, 1, 2'd0);
        l = int'(SD);
        pexp = 0;
        for (int k = 1; k <= 4; k++) begin
            wait_strobe(20, n, ok);
            check($sformatf("lfsr_strobe%0d", k), n, ok ? 7 : -1);
            tick();
            pexp = (pexp * 2 + (l % 2)) % (1 << W);
            l = lfsr_next(l);
            if (k == 1) check("lfsr_first_bit", led_n, 6'h3E);
            check($sformatf("lfsr_led%0d", k), led_n, (~pexp) & 6'h3F);
        end

        // ---------------- full drain from all-on ----------------
        apply(1, 0, 0, 0, 0, 2'd0); tick();
        apply(0, 1, 0, 0, 0, 2'd0); tick();
        apply(0, 0, 0, 0, 0, 2'd0);
        n = 0;
        while (led_n !== 6'h00 && n < 100) begin tick(); n++; end
        check("fill_led", led_n, 6'h00);
        stop = 1'b1; tick();
        stop = 1'b0; start = 1'b1;
        check("drain_state", state, 2'd2);
        check("drain_busy", busy, 1'b1);
        for (int k = 1; k <= W; k++) begin
            wait_strobe(20, n, ok);
            check($sformatf("drain_strobe%0d", k), ok, 1'b1);
            if (k == W) start = 1'b0;
            tick();
            check($sformatf("drain_led%0d", k), led_n, (1 << k) - 1);
            check($sformatf("drain_st%0d", k), state, (k < W) ? 2 : 0);
        end
        tick();
        check("drain_idle_after", {busy, state}, 3'b000);

        // ------- stop on a strobe, then reset mid-DRAIN -------
        apply(1, 0, 0, 0, 0, 2'd3); tick();
        apply(0, 1, 0, 0, 0, 2'd3); tick();
        apply(0, 0, 0, 0, 0, 2'd3);
        tick(); tick(); tick();
        stop = 1'b1; tick();
        stop = 1'b0;
        check("stop_strobe_led", led_n, 6'h30);
        check("stop_strobe_state", state, 2'd2);
        reset = 1'b1; tick();
        check("rst_drain", {led_n, busy, state, strobe}, {6'h3F, 1'b0, 2'd0, 1'b0});
        apply(0, 1, 0, 0, 0, 2'd0); tick();
        start = 1'b0;
        wait_strobe(20, n, ok);
        check("restart_gap", n, ok ? 7 : -1);
        tick();
        check("restart_led", led_n, 6'h3E);

        // ---------------- randomized vs model ----------------
        apply(1, 0, 0, 0, 0, 2'd0);
        model_step(1, 0, 0, 0, 0, 2'd0);
        tick();
        for (int c = 0; c < 4000; c++) begin
            logic r, st, sp, ss, dn;
            logic [1:0] ps;
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 39) == 0);
            ss = $urandom_range(0, 1);
            dn = $urandom_range(0, 1);
            ps = 2'($urandom_range(0, 3));
            apply(r, st, sp, ss, dn, ps);
            model_step(r, st, sp, ss, dn, ps);
            tick();
            check($sformatf("rand%0d", c), {led_n, strobe, busy, state},
                  {6'(((1 << W) - 1) - m_pat), 1'(m_mode != 0 && m_rem == 1),
                   1'(m_mode != 0), 2'(m_mode)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
